ddr4_req_sched: RTL

Host-side request scheduler that sits directly upstream of the DDR4 controller state machine. It accepts host read/write requests over a valid/ready handshake and buffers them in a small FIFO. Each host address is decoded into bank group, bank, row and column fields. An open-row table is kept per bank, and each request is converted into the DDR4 command sequence the controller executes (PRE, ACT, RD/WR), one command per handshake.

---
 rtl/ddr4_pkg.sv | 37 +++
 rtl/ddr4_req_sched_if.sv | 45 ++++
 rtl/ddr4_req_fifo.sv | 50 +++++
 rtl/ddr4_req_sched.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ddr4_pkg.sv
// Shared constants, address layout and FSM states
// for the DDR4 host request scheduler.
package ddr4_pkg;

  localparam int BG_W   = 2;
  localparam int BA_W   = 2;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 4;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = BG_W + BA_W;

  localparam int BG_LSB  = 14;
  localparam int BA_LSB  = 12;
  localparam int ROW_LSB = 4;
  localparam int COL_LSB = 0;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PRE,
    S_ACT,
    S_CAS,
    S_AUTO_PRE
  } state_t;

  function automatic logic [1:0] cas_type(
    input logic we
  );
    return we ? CMD_WR : CMD_RD;
  endfunction

endpackage

// File: rtl/ddr4_req_sched_if.sv
// Host request and controller command handshakes.
// slave = scheduler side, master = host/controller side.
interface ddr4_req_sched_if #(
  parameter int DATA_W = 8
);
  import ddr4_pkg::*;

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [BG_W-1:0]   cmd_bg;
  logic [BA_W-1:0]   cmd_ba;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic [DATA_W-1:0] cmd_wdata;

  modport slave (
    input  host_valid, host_we,
    input  host_addr, host_wdata,
    output host_ready,
    input  cmd_ready,
    output cmd_valid, cmd_type,
    output cmd_bg, cmd_ba,
    output cmd_row, cmd_col,
    output cmd_wdata
  );

  modport master (
    output host_valid, host_we,
    output host_addr, host_wdata,
    input  host_ready,
    output cmd_ready,
    input  cmd_valid, cmd_type,
    input  cmd_bg, cmd_ba,
    input  cmd_row, cmd_col,
    input  cmd_wdata
  );

endinterface

// File: rtl/ddr4_req_fifo.sv
// Synchronous request FIFO holding {we, addr, wdata}.
// DEPTH must be a power of two so pointers wrap naturally.
module ddr4_req_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 25,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_50mhz,
  input  logic          rst_50mhz,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_50mhz) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push)
                     - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ddr4_req_sched.sv
// DDR4 request scheduler: FIFO, open-row table, PRE/ACT/CAS FSM.
// Define DDR4_CLOSE_PAGE_EN for close-page (auto PRE after CAS).
module ddr4_req_sched
  import ddr4_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic clk_50mhz,
  input  logic rst_50mhz,
  input  logic init_done,
  ddr4_req_sched_if.slave bus,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic busy
);

  localparam int FW = 1 + ADDR_W + DATA_W;

  logic [FW-1:0]     head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              accept;

  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [BG_W-1:0]   h_bg;
  logic [BA_W-1:0]   h_ba;
  logic [ROW_W-1:0]  h_row;
  logic [COL_W-1:0]  h_col;
  logic [IDX_W-1:0]  h_idx;
  logic [IDX_W-1:0]  c_idx;
  logic              h_open;
  logic              h_same;

  logic [15:0]       open_q;
  logic [ROW_W-1:0]  row_q [16];

  state_t            state;
  logic              cmd_valid_q;
  logic [1:0]        cmd_type_q;
  logic [BG_W-1:0]   cmd_bg_q;
  logic [BA_W-1:0]   cmd_ba_q;
  logic [ROW_W-1:0]  cmd_row_q;
  logic [COL_W-1:0]  cmd_col_q;
  logic [DATA_W-1:0] cmd_wdata_q;

  assign bus.host_ready = ~full;
  assign push   = bus.host_valid & ~full;
  assign accept = cmd_valid_q & bus.cmd_ready;
  assign pop    = (state == S_CAS) & accept;

  ddr4_req_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk_50mhz (clk_50mhz),
    .rst_50mhz (rst_50mhz),
    .push      (push),
    .pop       (pop),
    .din       ({bus.host_we,
                 bus.host_addr,
                 bus.host_wdata}),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (q_count)
  );

  assign h_we    = head[FW-1];
  assign h_addr  = head[FW-2 -: ADDR_W];
  assign h_wdata = head[DATA_W-1:0];
  assign h_bg    = h_addr[BG_LSB  +: BG_W];
  assign h_ba    = h_addr[BA_LSB  +: BA_W];
  assign h_row   = h_addr[ROW_LSB +: ROW_W];
  assign h_col   = h_addr[COL_LSB +: COL_W];
  assign h_idx   = {h_bg, h_ba};
  assign c_idx   = {cmd_bg_q, cmd_ba_q};
  assign h_open  = open_q[h_idx];
  assign h_same  = (row_q[h_idx] == h_row);

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.cmd_wdata = cmd_wdata_q;

  assign busy = (state != S_IDLE)
              | (q_count != '0);

  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      state       <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_ACT;
      cmd_bg_q    <= '0;
      cmd_ba_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_wdata_q <= '0;
      open_q      <= '0;
      for (int i = 0; i < 16; i++)
        row_q[i] <= '0;
    end else begin
      // Bank state follows commands the controller took,
      // keyed by the latched target rather than the head.
      if (accept && cmd_type_q == CMD_ACT) begin
        open_q[c_idx] <= 1'b1;
        row_q[c_idx]  <= cmd_row_q;
      end else if (accept && cmd_type_q == CMD_PRE) begin
        open_q[c_idx] <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (!empty && init_done)
            state <= S_CHECK;
        end
        S_CHECK: begin
          cmd_valid_q <= 1'b1;
          cmd_bg_q    <= h_bg;
          cmd_ba_q    <= h_ba;
          cmd_row_q   <= h_row;
          cmd_col_q   <= h_col;
          cmd_wdata_q <= h_wdata;
          unique case (1'b1)
            (h_open && h_same): begin
              state      <= S_CAS;
              cmd_type_q <= cas_type(h_we);
            end
            (h_open && !h_same): begin
              state      <= S_PRE;
              cmd_type_q <= CMD_PRE;
            end
            (!h_open): begin
              state      <= S_ACT;
              cmd_type_q <= CMD_ACT;
            end
          endcase
        end
        S_PRE: begin
          if (accept) begin
            state      <= S_ACT;
            cmd_type_q <= CMD_ACT;
          end
        end
        S_ACT: begin
          if (accept) begin
            state      <= S_CAS;
            cmd_type_q <= cas_type(h_we);
          end
        end
        S_CAS: begin
          if (accept) begin
`ifdef DDR4_CLOSE_PAGE_EN
            state      <= S_AUTO_PRE;
            cmd_type_q <= CMD_PRE;
`else
            state       <= S_IDLE;
            cmd_valid_q <= 1'b0;
`endif
          end
        end
        S_AUTO_PRE: begin
          if (accept) begin
            state       <= S_IDLE;
            cmd_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
